// File: rtl/pipe_instruction_control.sv
// -----------------------------------------------------------------------------
// pipe_instruction_control
//
// ID-stage control decoder for a pipelined RV32I core. The decoded control
// bundle is captured in a single ID/EX register. A valid/ready handshake is
// used on both sides of that register.
//   - Load-use hazards hold the ID instruction back. The EX stage drains,
//     which leaves a one-cycle bubble.
//   - A taken branch or jump (flush) squashes both the ID/EX entry and the
//     instruction currently presented in ID.
//   - Loads and stores in EX are steered to RAM or IO. The choice depends on
//     whether the ALU result high bits fall in the IO window.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   id_valid/ready   handshake with IF/ID (id_ready is combinational)
//   instruction      RV32I instruction word presented by IF/ID
//   ex_ready         downstream consumes the ID/EX entry this cycle
//   flush            branch/jump taken in EX
//   Alu_resultHigh   EX-stage ALU result high bits, used for IO select
//   ex_valid, ex_rd  ID/EX occupancy and destination register
//   ex_illegal       ID/EX entry has an unsupported opcode/funct
//   Branch .. sftmd  registered control fields of the ID/EX entry
//   ALUop            registered ALU operation
//   MemRead .. MemorIOToReg  EX-stage RAM/IO access select
// -----------------------------------------------------------------------------
module pipe_instruction_control #(
    parameter int unsigned              ADDR_HIGH_W = 22,
    parameter logic [ADDR_HIGH_W-1:0]   IO_HIGH_VAL = 22'h3FFFFF,
    parameter bit                       HAZARD_EN   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [31:0]            instruction,
    input  logic                   ex_ready,
    input  logic                   flush,
    input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
    output logic                   ex_valid,
    output logic [4:0]             ex_rd,
    output logic                   ex_illegal,
    output logic                   Branch,
    output logic                   nBranch,
    output logic                   branch_lt,
    output logic                   branch_ge,
    output logic                   branch_ltu,
    output logic                   branch_geu,
    output logic                   jal,
    output logic                   jalr,
    output logic                   ALUSrc,
    output logic                   RegWrite,
    output logic                   sftmd,
    output logic [3:0]             ALUop,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IORead,
    output logic                   IOWrite,
    output logic                   MemorIOToReg
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef struct packed {
        logic       illegal;
        logic [4:0] rd;
        logic       branch;
        logic       nbranch;
        logic       br_lt;
        logic       br_ge;
        logic       br_ltu;
        logic       br_geu;
        logic       jal;
        logic       jalr;
        logic       alu_src;
        logic       reg_write;
        logic       sftmd;
        alu_op_e    alu_op;
        logic       is_load;
        logic       is_store;
    } ctrl_t;

    // funct3 -> ALU operation. alt selects sub/sra, i.e. funct7[5] for the
    // forms where it is meaningful.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    ctrl_t dec;
    ctrl_t ex_q;
    logic  uses_rs1;
    logic  uses_rs2;
    logic  legal;
    logic  hazard;

    // ---------------------------------------------------------------- decode
    always_comb begin
        // NOTE: every variable gets a default before the case, so paths that
        // do not assign it cannot infer a latch.
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OPC_OP: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                dec.sftmd     = (funct3 == 3'b001) || (funct3 == 3'b101);
                if (funct7 == 7'b0000000)
                    dec.alu_op = alu_from_f3(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    dec.alu_op = alu_from_f3(funct3, 1'b1);
                else
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                uses_rs1      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                dec.sftmd     = (funct3 == 3'b001) || (funct3 == 3'b101);
                // Only the shift-immediate forms carry a meaningful funct7.
                // There is no subi.
                dec.alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    legal = 1'b0;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    legal = 1'b0;
            end
            OPC_LOAD: begin
                uses_rs1      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                dec.is_load   = 1'b1;
                legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                dec.alu_src  = 1'b1;
                dec.is_store = 1'b1;
                legal = (funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_BRANCH: begin
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                dec.alu_op = ALU_SUB;
                case (funct3)
                    3'b000:  dec.branch  = 1'b1;
                    3'b001:  dec.nbranch = 1'b1;
                    3'b100:  dec.br_lt   = 1'b1;
                    3'b101:  dec.br_ge   = 1'b1;
                    3'b110:  dec.br_ltu  = 1'b1;
                    3'b111:  dec.br_geu  = 1'b1;
                    default: legal       = 1'b0;
                endcase
            end
            OPC_JAL: begin
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
            end
            OPC_JALR: begin
                uses_rs1      = 1'b1;
                dec.jalr      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
                legal         = (funct3 == 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = rd;
            end
            default: legal = 1'b0;
        endcase
        // An illegal instruction still occupies the slot. It carries no
        // control, so it cannot write state.
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------ hazard/handshake
    assign hazard = HAZARD_EN && ex_valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

    assign id_ready = !flush && !hazard && (!ex_valid || ex_ready);

    // --------------------------------------------------------- ID/EX register
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments. Every register
        // therefore samples pre-edge values, whatever order the statements run in.
        if (rst) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (id_valid && id_ready) begin
            ex_q     <= dec;
            ex_valid <= 1'b1;
        end else if (ex_valid && ex_ready) begin
            // Drained with nothing to load. During a hazard this is the bubble.
            ex_valid <= 1'b0;
        end
    end

    assign ex_rd      = ex_q.rd;
    assign ex_illegal = ex_q.illegal;
    assign Branch     = ex_q.branch;
    assign nBranch    = ex_q.nbranch;
    assign branch_lt  = ex_q.br_lt;
    assign branch_ge  = ex_q.br_ge;
    assign branch_ltu = ex_q.br_ltu;
    assign branch_geu = ex_q.br_geu;
    assign jal        = ex_q.jal;
    assign jalr       = ex_q.jalr;
    assign ALUSrc     = ex_q.alu_src;
    assign RegWrite   = ex_q.reg_write;
    assign sftmd      = ex_q.sftmd;
    assign ALUop      = ex_q.alu_op;

    // ------------------------------------------------------ RAM / IO select
    logic io_hit;
    logic ex_load;
    logic ex_store;

    assign io_hit   = (Alu_resultHigh == IO_HIGH_VAL);
    assign ex_load  = ex_valid && ex_q.is_load;
    assign ex_store = ex_valid && ex_q.is_store;

    assign MemRead      = ex_load  && !io_hit;
    assign IORead       = ex_load  &&  io_hit;
    assign MemWrite     = ex_store && !io_hit;
    assign IOWrite      = ex_store &&  io_hit;
    assign MemorIOToReg = ex_load;

endmodule

// File: tb/tb_pipe_instruction_control.sv
// -----------------------------------------------------------------------------
// tb_pipe_instruction_control
//
// The decode table pushes one instruction at a time through an empty ID/EX
// register. The whole registered bundle is then compared against a
// hand-written expected record. Hand-written sequences then cover:
//   - load-use stall, with a second instance that has the stall disabled
//   - RAM/IO select
//   - downstream stall
//   - flush
//   - reset mid-stall
// -----------------------------------------------------------------------------
module tb_pipe_instruction_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] instruction;
    logic        ex_ready;
    logic        flush;
    logic [21:0] Alu_resultHigh;

    logic       id_ready, ex_valid, ex_illegal;
    logic [4:0] ex_rd;
    logic       Branch, nBranch, branch_lt, branch_ge, branch_ltu, branch_geu;
    logic       jal, jalr, ALUSrc, RegWrite, sftmd;
    logic [3:0] ALUop;
    logic       MemRead, MemWrite, IORead, IOWrite, MemorIOToReg;

    logic       nh_id_ready, nh_ex_valid, nh_ex_illegal;
    logic [4:0] nh_ex_rd;
    logic       nh_Branch, nh_nBranch, nh_branch_lt, nh_branch_ge, nh_branch_ltu, nh_branch_geu;
    logic       nh_jal, nh_jalr, nh_ALUSrc, nh_RegWrite, nh_sftmd;
    logic [3:0] nh_ALUop;
    logic       nh_MemRead, nh_MemWrite, nh_IORead, nh_IOWrite, nh_MemorIOToReg;

    always #5 clk = ~clk;

    pipe_instruction_control u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .instruction(instruction), .ex_ready(ex_ready), .flush(flush),
        .Alu_resultHigh(Alu_resultHigh), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal), .Branch(Branch), .nBranch(nBranch),
        .branch_lt(branch_lt), .branch_ge(branch_ge), .branch_ltu(branch_ltu),
        .branch_geu(branch_geu), .jal(jal), .jalr(jalr), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .sftmd(sftmd), .ALUop(ALUop), .MemRead(MemRead),
        .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite),
        .MemorIOToReg(MemorIOToReg)
    );

    pipe_instruction_control #(.HAZARD_EN(1'b0)) u_dut_nh (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(nh_id_ready),
        .instruction(instruction), .ex_ready(ex_ready), .flush(flush),
        .Alu_resultHigh(Alu_resultHigh), .ex_valid(nh_ex_valid), .ex_rd(nh_ex_rd),
        .ex_illegal(nh_ex_illegal), .Branch(nh_Branch), .nBranch(nh_nBranch),
        .branch_lt(nh_branch_lt), .branch_ge(nh_branch_ge), .branch_ltu(nh_branch_ltu),
        .branch_geu(nh_branch_geu), .jal(nh_jal), .jalr(nh_jalr), .ALUSrc(nh_ALUSrc),
        .RegWrite(nh_RegWrite), .sftmd(nh_sftmd), .ALUop(nh_ALUop), .MemRead(nh_MemRead),
        .MemWrite(nh_MemWrite), .IORead(nh_IORead), .IOWrite(nh_IOWrite),
        .MemorIOToReg(nh_MemorIOToReg)
    );

    // flags: {Branch,nBranch,lt,ge,ltu,geu,jal,jalr,ALUSrc,RegWrite,sftmd}
    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [10:0] flags;
        logic [3:0]  op;
        logic        ld;   // MemorIOToReg
        logic        st;   // MemWrite | IOWrite
    } ctl_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        ctl_t        exp;
    } vec_t;

    ctl_t act_ctl;
    assign act_ctl = {ex_illegal, ex_rd,
                      Branch, nBranch, branch_lt, branch_ge, branch_ltu, branch_geu,
                      jal, jalr, ALUSrc, RegWrite, sftmd,
                      ALUop, MemorIOToReg, (MemWrite | IOWrite)};

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    function automatic ctl_t mkc(input logic [4:0] rd, input logic [10:0] f,
                                 input logic [3:0] op, input logic ld,
                                 input logic st, input logic ill);
        return {ill, rd, f, op, ld, st};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_type(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input logic [2:0] f3);
        return {7'b0, rs2, rs1, f3, 5'b01000, 7'b1100011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr, input ctl_t exp);
        vec_t v;
        v.name  = name;
        v.instr = instr;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        Alu_resultHigh = '0; instruction = 32'h0000_0013;
        tick(); tick();
        rst = 1'b0;
    endtask

    logic [31:0] lw_x5, add_x6, addi_x1;

    initial begin
        lw_x5   = i_type(12'd4, 5'd0, 3'b010, 5'd5, 7'b0000011);
        add_x6  = r_type(7'h00, 5'd1, 5'd5, 3'b000, 5'd6);
        addi_x1 = i_type(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);

        add_vec("addi",  addi_x1,                                       mkc(5'd1, 11'b00000000110, 4'b0000, 0, 0, 0));
        add_vec("add",   add_x6,                                        mkc(5'd6, 11'b00000000010, 4'b0000, 0, 0, 0));
        add_vec("sub",   r_type(7'h20, 5'd3, 5'd2, 3'b000, 5'd7),       mkc(5'd7, 11'b00000000010, 4'b0001, 0, 0, 0));
        add_vec("and",   r_type(7'h00, 5'd3, 5'd2, 3'b111, 5'd8),       mkc(5'd8, 11'b00000000010, 4'b0010, 0, 0, 0));
        add_vec("or",    r_type(7'h00, 5'd3, 5'd2, 3'b110, 5'd8),       mkc(5'd8, 11'b00000000010, 4'b0011, 0, 0, 0));
        add_vec("xor",   r_type(7'h00, 5'd3, 5'd2, 3'b100, 5'd8),       mkc(5'd8, 11'b00000000010, 4'b0100, 0, 0, 0));
        add_vec("sll",   r_type(7'h00, 5'd3, 5'd2, 3'b001, 5'd8),       mkc(5'd8, 11'b00000000011, 4'b0101, 0, 0, 0));
        add_vec("srl",   r_type(7'h00, 5'd3, 5'd2, 3'b101, 5'd8),       mkc(5'd8, 11'b00000000011, 4'b0110, 0, 0, 0));
        add_vec("sra",   r_type(7'h20, 5'd3, 5'd2, 3'b101, 5'd8),       mkc(5'd8, 11'b00000000011, 4'b0111, 0, 0, 0));
        add_vec("slt",   r_type(7'h00, 5'd3, 5'd2, 3'b010, 5'd8),       mkc(5'd8, 11'b00000000010, 4'b1000, 0, 0, 0));
        add_vec("sltu",  r_type(7'h00, 5'd3, 5'd2, 3'b011, 5'd8),       mkc(5'd8, 11'b00000000010, 4'b1001, 0, 0, 0));
        add_vec("srai",  i_type({7'b0100000, 5'd3}, 5'd9, 3'b101, 5'd9, 7'b0010011), mkc(5'd9, 11'b00000000111, 4'b0111, 0, 0, 0));
        add_vec("slli",  i_type({7'b0000000, 5'd2}, 5'd9, 3'b001, 5'd9, 7'b0010011), mkc(5'd9, 11'b00000000111, 4'b0101, 0, 0, 0));
        add_vec("xori",  i_type(12'h0FF, 5'd9, 3'b100, 5'd10, 7'b0010011), mkc(5'd10, 11'b00000000110, 4'b0100, 0, 0, 0));
        add_vec("lw",    lw_x5,                                         mkc(5'd5, 11'b00000000110, 4'b0000, 1, 0, 0));
        add_vec("sw",    s_type(12'd8, 5'd5, 5'd2, 3'b010),             mkc(5'd0, 11'b00000000100, 4'b0000, 0, 1, 0));
        add_vec("beq",   b_type(5'd2, 5'd1, 3'b000),                    mkc(5'd0, 11'b10000000000, 4'b0001, 0, 0, 0));
        add_vec("bne",   b_type(5'd2, 5'd1, 3'b001),                    mkc(5'd0, 11'b01000000000, 4'b0001, 0, 0, 0));
        add_vec("blt",   b_type(5'd2, 5'd1, 3'b100),                    mkc(5'd0, 11'b00100000000, 4'b0001, 0, 0, 0));
        add_vec("bge",   b_type(5'd2, 5'd1, 3'b101),                    mkc(5'd0, 11'b00010000000, 4'b0001, 0, 0, 0));
        add_vec("bltu",  b_type(5'd2, 5'd1, 3'b110),                    mkc(5'd0, 11'b00001000000, 4'b0001, 0, 0, 0));
        add_vec("bgeu",  b_type(5'd2, 5'd1, 3'b111),                    mkc(5'd0, 11'b00000100000, 4'b0001, 0, 0, 0));
        add_vec("jal",   {20'h00100, 5'd1, 7'b1101111},                 mkc(5'd1, 11'b00000010010, 4'b0000, 0, 0, 0));
        add_vec("jalr",  i_type(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111), mkc(5'd1, 11'b00000001110, 4'b0000, 0, 0, 0));
        add_vec("lui",   {20'h12345, 5'd3, 7'b0110111},                 mkc(5'd3, 11'b00000000110, 4'b0000, 0, 0, 0));
        add_vec("auipc", {20'h12345, 5'd4, 7'b0010111},                 mkc(5'd4, 11'b00000000110, 4'b0000, 0, 0, 0));
        add_vec("ill_opc",  {25'h1ABCDEF, 7'b1111111},                  mkc(5'd0, 11'b0, 4'b0000, 0, 0, 1));
        add_vec("ill_mul",  r_type(7'h01, 5'd3, 5'd2, 3'b000, 5'd8),    mkc(5'd0, 11'b0, 4'b0000, 0, 0, 1));
        add_vec("ill_br010", b_type(5'd2, 5'd1, 3'b010),                mkc(5'd0, 11'b0, 4'b0000, 0, 0, 1));

        // ------------------------------------------------------------ reset
        do_reset();
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_ctl",      {9'b0, act_ctl}, 32'd0);
        check("rst_access",   {27'b0, MemRead, MemWrite, IORead, IOWrite, MemorIOToReg}, 32'd0);
        check("rst_id_ready", {31'b0, id_ready}, 32'd1);

        // ------------------------------------------------------ decode table
        foreach (vecs[i]) begin
            instruction = vecs[i].instr;
            id_valid    = 1'b1;
            tick();
            check({vecs[i].name, "_valid"}, {31'b0, ex_valid}, 32'd1);
            check(vecs[i].name, {9'b0, act_ctl}, {9'b0, vecs[i].exp});
            id_valid = 1'b0;
            tick();
        end

        // -------------------------------------------------- load-use hazard
        do_reset();
        instruction = lw_x5; id_valid = 1'b1;
        tick();
        check("lu_load_in_ex", {31'b0, ex_valid}, 32'd1);
        instruction = add_x6;
        #1;
        check("lu_stall",     {31'b0, id_ready},    32'd0);
        check("lu_nh_nostall", {31'b0, nh_id_ready}, 32'd1);
        tick();
        check("lu_bubble",    {31'b0, ex_valid}, 32'd0);
        check("lu_nh_issued", {27'b0, nh_ex_rd}, 32'd6);
        check("lu_ready_after", {31'b0, id_ready}, 32'd1);
        tick();
        check("lu_add_issued", {22'b0, ex_valid, ex_rd, ALUop}, {22'b0, 1'b1, 5'd6, 4'b0000});
        id_valid = 1'b0;
        tick();
        // rs2 path: a store of the loaded register must also wait.
        instruction = lw_x5; id_valid = 1'b1;
        tick();
        instruction = s_type(12'd0, 5'd5, 5'd2, 3'b010);
        #1;
        check("lu_rs2_stall", {31'b0, id_ready}, 32'd1 - 32'd1);
        instruction = addi_x1;
        #1;
        check("lu_unrelated", {31'b0, id_ready}, 32'd1);
        id_valid = 1'b0;
        tick();
        // A load to x0 never causes a stall.
        instruction = i_type(12'd0, 5'd0, 3'b010, 5'd0, 7'b0000011); id_valid = 1'b1;
        tick();
        instruction = r_type(7'h00, 5'd1, 5'd0, 3'b000, 5'd6);
        #1;
        check("lu_x0_nostall", {31'b0, id_ready}, 32'd1);
        id_valid = 1'b0;
        tick();

        // --------------------------------------------------- RAM/IO select
        do_reset();
        instruction = lw_x5; id_valid = 1'b1;
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        Alu_resultHigh = 22'h000010;
        #1;
        check("ld_ram", {29'b0, MemRead, IORead, MemorIOToReg}, {29'b0, 3'b101});
        Alu_resultHigh = 22'h3FFFFF;
        #1;
        check("ld_io",  {29'b0, MemRead, IORead, MemorIOToReg}, {29'b0, 3'b011});
        Alu_resultHigh = 22'h3FFFFE;
        #1;
        check("ld_edge", {29'b0, MemRead, IORead, MemorIOToReg}, {29'b0, 3'b101});

        // ------------------------------------------- store + downstream stall
        ex_ready = 1'b1;
        tick();
        instruction = s_type(12'd8, 5'd5, 5'd2, 3'b010); id_valid = 1'b1;
        tick();
        Alu_resultHigh = 22'h3FFFFF; ex_ready = 1'b0; instruction = addi_x1;
        #1;
        check("st_io", {28'b0, IOWrite, MemWrite, IORead, MemRead}, {28'b0, 4'b1000});
        for (int c = 0; c < 3; c++) begin
            check("stall_id_ready", {31'b0, id_ready}, 32'd0);
            tick();
            check("stall_hold", {28'b0, ex_valid, IOWrite, ALUSrc, RegWrite}, {28'b0, 4'b1110});
        end
        ex_ready = 1'b1;
        #1;
        check("stall_release", {31'b0, id_ready}, 32'd1);
        tick();
        check("stall_next", {26'b0, ex_rd, RegWrite}, {26'b0, 5'd1, 1'b1});
        id_valid = 1'b0; Alu_resultHigh = '0;
        tick();

        // ------------------------------------------------------------ flush
        begin
            logic [31:0] fl_instr [4];
            logic [3:0]  fl_exp   [4];
            fl_instr[0] = b_type(5'd2, 5'd1, 3'b000);                    fl_exp[0] = 4'b1000;
            fl_instr[1] = b_type(5'd2, 5'd1, 3'b001);                    fl_exp[1] = 4'b0100;
            fl_instr[2] = b_type(5'd2, 5'd1, 3'b100);                    fl_exp[2] = 4'b0010;
            fl_instr[3] = i_type(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111); fl_exp[3] = 4'b0001;
            for (int k = 0; k < 4; k++) begin
                instruction = fl_instr[k]; id_valid = 1'b1;
                tick();
                check("fl_decode", {28'b0, Branch, nBranch, branch_lt, jalr}, {28'b0, fl_exp[k]});
                flush = 1'b1; instruction = addi_x1;
                #1;
                check("fl_id_ready", {31'b0, id_ready}, 32'd0);
                tick();
                flush = 1'b0; id_valid = 1'b0;
                check("fl_squash", {31'b0, ex_valid}, 32'd0);
                tick();
                check("fl_not_taken", {31'b0, ex_valid}, 32'd0);
            end
        end

        // Flush during hazard + stall: flush wins, no extra bubble.
        instruction = lw_x5; id_valid = 1'b1;
        tick();
        instruction = add_x6; ex_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flhz_squash", {31'b0, ex_valid}, 32'd0);
        #1;
        check("flhz_ready", {31'b0, id_ready}, 32'd1);
        tick();
        check("flhz_issue", {26'b0, ex_valid, ex_rd}, {26'b0, 1'b1, 5'd6});
        id_valid = 1'b0; ex_ready = 1'b1;
        tick();

        // ------------------------------------------------- reset mid-stall
        instruction = lw_x5; id_valid = 1'b1;
        tick();
        ex_ready = 1'b0; instruction = add_x6; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_valid", {31'b0, ex_valid}, 32'd0);
        check("rstmid_ctl",   {9'b0, act_ctl}, 32'd0);
        check("rstmid_access", {27'b0, MemRead, MemWrite, IORead, IOWrite, MemorIOToReg}, 32'd0);
        check("rstmid_ready", {31'b0, id_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
